// File: rtl/miriscv_fetch_pkg.sv
// Shared types and constants for the miriscv instruction fetch stage.
package miriscv_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR     = 32'h0000_0013;
    localparam logic [XLEN-1:0] FETCH_PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Sequential PC, wraps modulo 2^XLEN
    function automatic logic [XLEN-1:0] fetch_pc_inc(input logic [XLEN-1:0] pc);
        return pc + FETCH_PC_STEP;
    endfunction

endpackage

// File: rtl/miriscv_fetch_fifo.sv
// Prefetch FIFO for the fetch stage: synchronous reset and flush, same-cycle push/pop.
module miriscv_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = logic [63:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    output entry_t                       head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            pop_en;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];
    assign pop_en = pop & ~empty;

    // Pointer and occupancy bookkeeping; flush drops everything
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop_en);
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push && !flush && !rst_i) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/miriscv_fetch_stage.sv
// miriscv instruction fetch stage: PC ownership, in-order memory requests, prefetch FIFO.
// Optional same-cycle response bypass to decode: define MIRISCV_FETCH_BYPASS_EN.
module miriscv_fetch_stage
    import miriscv_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   boot_addr_i,

    output logic              instr_req_o,
    output logic [XLEN-1:0]   instr_addr_o,
    input  logic              instr_rvalid_i,
    input  logic [ILEN-1:0]   instr_rdata_i,

    input  logic [XLEN-1:0]   cu_pc_bra_i,
    input  logic              cu_boot_addr_load_en_i,
    input  logic              cu_stall_f_i,
    input  logic              cu_kill_f_i,

    output logic [ILEN-1:0]   f_instr_o,
    output logic [XLEN-1:0]   f_current_pc_o,
    output logic [XLEN-1:0]   f_next_pc_o,
    output logic              f_valid_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   discard_q;

    logic            boot_load;
    logic            kill;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            bypass;
    logic            accept_rsp;
    logic            fifo_push;
    logic            fifo_pop;
    logic            credit_pop;
    logic [SW-1:0]   credit_used;

    fetch_entry_t    push_entry;
    fetch_entry_t    fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    // Boot load outranks kill; a kill while stalled is held off by the control unit
    assign boot_load   = cu_boot_addr_load_en_i;
    assign kill        = cu_kill_f_i & ~cu_stall_f_i & ~boot_load;
    assign redirect    = boot_load | kill;
    assign redirect_pc = boot_load ? boot_addr_i : cu_pc_bra_i;

`ifdef MIRISCV_FETCH_BYPASS_EN
    assign bypass = instr_rvalid_i & fifo_empty & (discard_q == '0) & ~cu_stall_f_i & ~redirect;
`else
    assign bypass = 1'b0;
`endif

    assign accept_rsp = instr_rvalid_i & (discard_q == '0) & ~redirect;
    assign fifo_push  = accept_rsp & ~bypass;
    assign fifo_pop   = ~fifo_empty & ~cu_stall_f_i & ~kill;
    assign credit_pop = f_valid_o & ~cu_stall_f_i & ~kill;

    // Entries plus in-flight requests never exceed the FIFO size
    assign credit_used = SW'(fifo_count) + SW'(outstanding_q) - SW'(credit_pop);
    assign instr_req_o = ~rst_i & ~redirect & (credit_used < SW'(FIFO_DEPTH));
    assign instr_addr_o = fetch_pc_q;

    assign push_entry.instr = instr_rdata_i;
    assign push_entry.pc    = resp_pc_q;

    miriscv_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Fetch PC, response PC and in-flight accounting
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= '0;
            resp_pc_q     <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else if (redirect) begin
            fetch_pc_q    <= redirect_pc;
            resp_pc_q     <= redirect_pc;
            outstanding_q <= outstanding_q - CW'(instr_rvalid_i);
            discard_q     <= outstanding_q - CW'(instr_rvalid_i);
        end else begin
            if (instr_req_o) fetch_pc_q <= fetch_pc_inc(fetch_pc_q);
            outstanding_q <= outstanding_q + CW'(instr_req_o) - CW'(instr_rvalid_i);
            if (instr_rvalid_i) begin
                if (discard_q != '0) discard_q <= discard_q - CW'(1);
                else                 resp_pc_q <= fetch_pc_inc(resp_pc_q);
            end
        end
    end

    // Decode always executes its input, so an empty stage shows a NOP bubble
    always_comb begin
        f_valid_o      = 1'b0;
        f_instr_o      = NOP_INSTR;
        f_current_pc_o = resp_pc_q;
        if (bypass) begin
            f_valid_o      = 1'b1;
            f_instr_o      = instr_rdata_i;
            f_current_pc_o = resp_pc_q;
        end else if (!fifo_empty) begin
            f_valid_o      = 1'b1;
            f_instr_o      = fifo_head.instr;
            f_current_pc_o = fifo_head.pc;
        end
    end

    assign f_next_pc_o = fetch_pc_inc(f_current_pc_o);

    rsp_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_i |-> (outstanding_q != '0));

    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_miriscv_fetch_stage.sv
// Directed self-checking bench for miriscv_fetch_stage with a variable-latency memory model.
module tb_miriscv_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] boot_addr_i = '0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic [31:0] cu_pc_bra_i = '0;
    logic        cu_boot_addr_load_en_i = 1'b0;
    logic        cu_stall_f_i = 1'b0;
    logic        cu_kill_f_i = 1'b0;
    logic [31:0] f_instr_o;
    logic [31:0] f_current_pc_o;
    logic [31:0] f_next_pc_o;
    logic        f_valid_o;

`ifdef MIRISCV_FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned mem_lat = 1;
    logic        pv [4];
    logic [31:0] pa [4];

    miriscv_fetch_stage #(.FIFO_DEPTH(2)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .boot_addr_i            (boot_addr_i),
        .instr_req_o            (instr_req_o),
        .instr_addr_o           (instr_addr_o),
        .instr_rvalid_i         (instr_rvalid_i),
        .instr_rdata_i          (instr_rdata_i),
        .cu_pc_bra_i            (cu_pc_bra_i),
        .cu_boot_addr_load_en_i (cu_boot_addr_load_en_i),
        .cu_stall_f_i           (cu_stall_f_i),
        .cu_kill_f_i            (cu_kill_f_i),
        .f_instr_o              (f_instr_o),
        .f_current_pc_o         (f_current_pc_o),
        .f_next_pc_o            (f_next_pc_o),
        .f_valid_o              (f_valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // In-order memory: response mem_lat cycles after the accepted request
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= instr_req_o;
            pa[0] <= instr_addr_o;
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign instr_rvalid_i = pv[mem_lat-1];
    assign instr_rdata_i  = mem_word(pa[mem_lat-1]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic stall, input logic kill, input logic boot);
        @(negedge clk_i);
        cu_stall_f_i           = stall;
        cu_kill_f_i            = kill;
        cu_boot_addr_load_en_i = boot;
        #1;
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] pc;
        int          first;

        base = 32'h8000_0000;

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        chk("rst_req",   32'(instr_req_o), 32'd0);
        chk("rst_valid", 32'(f_valid_o), 32'd0);
        chk("rst_instr", f_instr_o, 32'h0000_0013);
        chk("rst_pc",    f_current_pc_o, 32'h0);
        chk("rst_npc",   f_next_pc_o, 32'h4);

        // Boot load
        @(negedge clk_i);
        rst_i = 1'b0;
        boot_addr_i = base;
        cu_boot_addr_load_en_i = 1'b1;
        #1;
        chk("boot_req", 32'(instr_req_o), 32'd0);

        step(1'b0, 1'b0, 1'b0);
        chk("c0_req",   32'(instr_req_o), 32'd1);
        chk("c0_addr",  instr_addr_o, base);
        chk("c0_valid", 32'(f_valid_o), 32'd0);
        chk("c0_pc",    f_current_pc_o, base);

        step(1'b0, 1'b0, 1'b0);
        chk("c1_req",   32'(instr_req_o), 32'd1);
        chk("c1_addr",  instr_addr_o, base + 32'h4);
        chk("c1_valid", 32'(f_valid_o), 32'(BYP));

        // Straight-line stream
        for (int i = 0; i < 8; i++) begin
            if (i > 0 || BYP == 0) step(1'b0, 1'b0, 1'b0);
            pc = base + 32'(4 * i);
            chk("sl_valid", 32'(f_valid_o), 32'd1);
            chk("sl_pc",    f_current_pc_o, pc);
            chk("sl_instr", f_instr_o, mem_word(pc));
            chk("sl_npc",   f_next_pc_o, pc + 32'h4);
            chk("sl_req",   32'(instr_req_o), 32'd1);
            chk("sl_addr",  instr_addr_o, base + 32'(4 * (i + 2 - BYP)));
        end

`ifndef MIRISCV_FETCH_BYPASS_EN
        // Stall: outputs frozen on instruction 8, credits exhausted
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("st_valid", 32'(f_valid_o), 32'd1);
            chk("st_pc",    f_current_pc_o, base + 32'h20);
            chk("st_instr", f_instr_o, mem_word(base + 32'h20));
            chk("st_req",   32'(instr_req_o), 32'd0);
        end

        // Release: no instruction lost
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
            pc = base + 32'h20 + 32'(4 * i);
            if (i == 0) begin
                chk("rl_req",  32'(instr_req_o), 32'd1);
                chk("rl_addr", instr_addr_o, base + 32'h28);
            end
            chk("rl_valid", 32'(f_valid_o), 32'd1);
            chk("rl_pc",    f_current_pc_o, pc);
            chk("rl_instr", f_instr_o, mem_word(pc));
        end

        // Reset with a full FIFO
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        mem_lat = 3;
        #1;
        chk("mr_req0", 32'(instr_req_o), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("mr_valid", 32'(f_valid_o), 32'd0);
        chk("mr_instr", f_instr_o, 32'h0000_0013);
        chk("mr_pc",    f_current_pc_o, 32'h0);
        chk("mr_req",   32'(instr_req_o), 32'd0);

        // Kill with two stale responses in flight (3-cycle memory)
        @(negedge clk_i);
        rst_i = 1'b0;
        boot_addr_i = 32'h0000_0200;
        cu_boot_addr_load_en_i = 1'b1;
        #1;
        step(1'b0, 1'b0, 1'b0);
        chk("k_e0_addr", instr_addr_o, 32'h200);
        chk("k_e0_req",  32'(instr_req_o), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("k_e1_addr", instr_addr_o, 32'h204);
        chk("k_e1_req",  32'(instr_req_o), 32'd1);
        cu_pc_bra_i = 32'h0000_0100;
        step(1'b0, 1'b1, 1'b0);
        chk("k_e2_req",  32'(instr_req_o), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("k_e3_req",   32'(instr_req_o), 32'd0);
        chk("k_e3_valid", 32'(f_valid_o), 32'd0);
        chk("k_e3_pc",    f_current_pc_o, 32'h100);
        step(1'b0, 1'b0, 1'b0);
        chk("k_e4_req",   32'(instr_req_o), 32'd1);
        chk("k_e4_addr",  instr_addr_o, 32'h100);
        chk("k_e4_valid", 32'(f_valid_o), 32'd0);

        first = 0;
        for (int n = 5; n < 25; n++) begin
            step(1'b0, 1'b0, 1'b0);
            if (f_valid_o) begin
                first = n;
                break;
            end
        end
        chk("k_first_cyc",   32'(first), 32'd8);
        chk("k_first_pc",    f_current_pc_o, 32'h100);
        chk("k_first_instr", f_instr_o, mem_word(32'h100));
        step(1'b0, 1'b0, 1'b0);
        chk("k_second_valid", 32'(f_valid_o), 32'd1);
        chk("k_second_pc",    f_current_pc_o, 32'h104);
        chk("k_second_instr", f_instr_o, mem_word(32'h104));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
